elastic_pipe_reg: RTL and testbench
===================================

Name: elastic_pipe_reg

Overview:
Parametrised chain of DEPTH level-free, clocked data registers with a per-stage valid bit and valid/ready handshake on both sides. It generalises the team's single enable-gated data latch into a stallable, flushable pipeline register. It sits between datapath units, e.g. UART RX → ALU operand path → UART TX, and absorbs back-pressure without losing or duplicating data.

Parameters:
SIZE_DATA, 8, data width in bits (≥1)
DEPTH, 2, number of register stages (≥1)
RESET_DATA, 0, value loaded into every stage data register on reset

Ports:
i_clk  in  1  clock; all state updates on rising edge
i_reset  in  1  reset, synchronous, active-high
i_enable  in  1  global advance enable; low freezes all state
i_flush  in  1  synchronous flush of all valid bits
i_data  in  SIZE_DATA  upstream data
i_valid  in  1  upstream data valid
o_ready  out  1  block can accept i_data this cycle
o_data  out  SIZE_DATA  data of last stage
o_valid  out  1  valid bit of last stage
i_ready  in  1  downstream accepts o_data

Behaviour:
- State: data[k] (SIZE_DATA), vld[k] (1), k = 0..DEPTH-1; stage 0 is input side, stage DEPTH-1 drives o_data/o_valid directly (registered outputs, no combinational path from i_data).
- Reset (i_reset=1 at edge): all vld[k]=0, all data[k]=RESET_DATA; o_valid=0, o_data=RESET_DATA. Reset has priority over flush and enable.
- Output fire: out_fire = o_valid & i_ready & i_enable. Input fire: in_fire = i_valid & o_ready.
- Stage advance condition (combinational, from output back): adv[DEPTH-1] = ~vld[DEPTH-1] | (i_ready & i_enable); adv[k] = ~vld[k] | adv[k+1], gated by i_enable. Bubbles collapse: an empty stage accepts even when downstream is stalled.
- o_ready = adv[0] & i_enable & ~i_flush & ~i_reset.
- On edge with i_enable=1, no reset/flush: for each k where adv[k]: stage k loads stage k-1 (data and vld); stage 0 loads i_data with vld[0]=in_fire. Stages with adv[k]=0 hold.
- Data registers of invalid stages may load don't-care values; only vld qualifies data. o_data when o_valid=0 is not checked except after reset.
- Latency: with i_ready=1 throughout, a beat accepted at edge N appears with o_valid=1 after edge N+DEPTH-1 (visible DEPTH cycles after i_valid sampled). Throughput 1 beat/cycle.
- Full: all vld=1 and i_ready=0 → o_ready=0; i_data ignored; contents hold.
- Simultaneous full and i_ready=1: o_ready=1 same cycle (pass-through of ready), accept and emit together, no bubble.
- i_enable=0: no state change, o_ready=0, out_fire=0 regardless of i_ready; o_valid/o_data stay stable.
- i_flush=1 (enable don't-care): all vld cleared at edge; data registers hold; incoming beat dropped (o_ready=0); out_fire is not counted even if i_ready=1 (downstream must qualify with i_enable & ~i_flush).
- Reset mid-stream: all in-flight beats discarded at the edge; no beat emitted in the reset cycle.
- Never: duplicate emission of a beat, reordering, loss of a beat without flush/reset.

Optional Feature:
ELASTIC_PIPE_COUNT_EN: when defined, adds output port o_count, width $clog2(DEPTH+1), = number of set vld bits, registered, updated same edge as vld (+1 on in_fire only, −1 on out_fire only, unchanged on both/neither; 0 on reset or flush). When undefined, the port and counter do not exist; all other behaviour identical.

Test Plan:
DEPTH=3, SIZE_DATA=8: reset, then i_valid=1 with 0x11,0x22,0x33 on consecutive cycles, i_ready=1 → o_valid rises 3 cycles after first accept, o_data 0x11,0x22,0x33 on consecutive cycles.
Fill with 0xA1,0xA2,0xA3 while i_ready=0 → o_ready=0 after 3rd accept, 4th beat 0xA4 not taken; raise i_ready → 0xA1..0xA4 emitted in order, no gap.
Full pipe, i_ready=1 and i_valid=1 same cycle → o_ready=1, one beat out and one in; count (if enabled) stays 3.
Two beats in flight, pulse i_flush one cycle with i_valid=1, i_ready=1 → o_valid=0 next cycle, no beat emitted, count=0; next beat 0x5C flows normally.
i_enable=0 for 4 cycles with 0x77 at output and i_ready=1 → o_data=0x77, o_valid=1 held, o_ready=0; re-enable → 0x77 emitted exactly once.
Reset asserted with 3 beats in flight → after edge o_valid=0, o_data=RESET_DATA, o_ready=1 once reset drops.

Source files
------------

// File: rtl/elastic_pipe_reg.sv
// elastic_pipe_reg: DEPTH-stage stallable, flushable pipeline register with a
// valid/ready handshake on both sides.
//
// Handshake: a beat moves across an interface on a rising edge exactly when
// valid and ready are both high in the cycle before that edge. Upstream:
// in_fire = i_valid & o_ready. Downstream: out_fire = o_valid & i_ready &
// i_enable, and downstream must also qualify with ~i_flush.
//
// Optional feature, enabled by defining ELASTIC_PIPE_COUNT_EN: adds the o_count
// output, a registered count of occupied stages.
module elastic_pipe_reg #(
    parameter int                   SIZE_DATA  = 8,
    parameter int                   DEPTH      = 2,
    parameter logic [SIZE_DATA-1:0] RESET_DATA = '0
) (
    input  logic                 i_clk,
    input  logic                 i_reset,
    input  logic                 i_enable,
    input  logic                 i_flush,
    input  logic [SIZE_DATA-1:0] i_data,
    input  logic                 i_valid,
    output logic                 o_ready,
    output logic [SIZE_DATA-1:0] o_data,
    output logic                 o_valid,
    input  logic                 i_ready
`ifdef ELASTIC_PIPE_COUNT_EN
    ,
    output logic [$clog2(DEPTH+1)-1:0] o_count
`endif
);

    // Stage 0 is the input side; stage DEPTH-1 drives the outputs directly.
    logic [SIZE_DATA-1:0] r_data [DEPTH];
    logic [DEPTH-1:0]     r_vld;
    logic [DEPTH-1:0]     w_adv;
    logic                 w_in_fire;
    logic                 w_out_fire;

    // Advance chain from the output back: an empty stage may always load,
    // so bubbles collapse even while the output is stalled.
    always_comb begin
        w_adv = '0;
        w_adv[DEPTH-1] = (~r_vld[DEPTH-1] | i_ready) & i_enable;
        for (int k = DEPTH - 2; k >= 0; k--) begin
            w_adv[k] = (~r_vld[k] | w_adv[k+1]) & i_enable;
        end
    end

    assign o_ready    = w_adv[0] & i_enable & ~i_flush & ~i_reset;
    assign w_in_fire  = i_valid & o_ready;
    assign w_out_fire = r_vld[DEPTH-1] & i_ready & i_enable;

    assign o_data  = r_data[DEPTH-1];
    assign o_valid = r_vld[DEPTH-1];

    // Stage registers: reset beats flush beats enable; advancing stages load
    // from their upstream neighbour, stalled stages hold.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            for (int k = 0; k < DEPTH; k++) begin
                r_data[k] <= RESET_DATA;
            end
            r_vld <= '0;
        end else if (i_flush) begin
            r_vld <= '0;
        end else if (i_enable) begin
            if (w_adv[0]) begin
                r_data[0] <= i_data;
                r_vld[0]  <= w_in_fire;
            end
            for (int k = 1; k < DEPTH; k++) begin
                if (w_adv[k]) begin
                    r_data[k] <= r_data[k-1];
                    r_vld[k]  <= r_vld[k-1];
                end
            end
        end
    end

`ifdef ELASTIC_PIPE_COUNT_EN
    localparam int CW = $clog2(DEPTH + 1);
    logic [CW-1:0] r_count;

    // Occupancy tracks vld bits: +1 on accept only, -1 on emit only.
    always_ff @(posedge i_clk) begin
        if (i_reset || i_flush) begin
            r_count <= '0;
        end else begin
            case ({w_in_fire, w_out_fire})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    assign o_count = r_count;
`endif

endmodule

// File: tb/tb_elastic_pipe_reg.sv
// Directed testbench for elastic_pipe_reg, DEPTH=3, SIZE_DATA=8. Inputs are
// driven 1 time unit after each rising edge; registered outputs are checked
// after the edge and o_ready after the inputs settle.
module tb_elastic_pipe_reg;

    localparam int          W     = 8;
    localparam int          D     = 3;
    localparam logic [W-1:0] RST_D = 8'hE5;

    logic         i_clk = 1'b0;
    logic         i_reset;
    logic         i_enable;
    logic         i_flush;
    logic [W-1:0] i_data;
    logic         i_valid;
    logic         o_ready;
    logic [W-1:0] o_data;
    logic         o_valid;
    logic         i_ready;
`ifdef ELASTIC_PIPE_COUNT_EN
    logic [$clog2(D+1)-1:0] o_count;
`endif

    int n_cmp  = 0;
    int n_fail = 0;

    elastic_pipe_reg #(.SIZE_DATA(W), .DEPTH(D), .RESET_DATA(RST_D)) dut (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .i_enable(i_enable),
        .i_flush (i_flush),
        .i_data  (i_data),
        .i_valid (i_valid),
        .o_ready (o_ready),
        .o_data  (o_data),
        .o_valid (o_valid),
        .i_ready (i_ready)
`ifdef ELASTIC_PIPE_COUNT_EN
        ,
        .o_count (o_count)
`endif
    );

    // Clock
    always #5 i_clk = ~i_clk;

    // Advance one clock edge and settle past it.
    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [W-1:0] d, input logic rdy);
        i_valid = v;
        i_data  = d;
        i_ready = rdy;
        #1;
    endtask

    task automatic test_reset();
        i_reset = 1'b1; i_enable = 1'b1; i_flush = 1'b0;
        drive(1'b1, 8'h3C, 1'b1);
        n_cmp++;
        if (o_ready !== 1'b0) begin
            n_fail++; $display("FAIL reset_ready: got %b want 0", o_ready);
        end
        tick(); tick();
        n_cmp++;
        if (o_valid !== 1'b0 || o_data !== RST_D) begin
            n_fail++; $display("FAIL reset_out: got v=%b d=%h want v=0 d=%h", o_valid, o_data, RST_D);
        end
        i_reset = 1'b0;
        drive(1'b0, 8'h00, 1'b1);
        n_cmp++;
        if (o_ready !== 1'b1) begin
            n_fail++; $display("FAIL reset_release_ready: got %b want 1", o_ready);
        end
    endtask

    task automatic test_stream();
        logic [W-1:0] beats [3];
        logic         exp_v [6];
        logic [W-1:0] exp_d [6];
        beats = '{8'h11, 8'h22, 8'h33};
        exp_v = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
        exp_d = '{8'h00, 8'h00, 8'h11, 8'h22, 8'h33, 8'h00};
        for (int c = 0; c < 6; c++) begin
            if (c < 3) drive(1'b1, beats[c], 1'b1);
            else       drive(1'b0, 8'h00, 1'b1);
            tick();
            n_cmp++;
            if (o_valid !== exp_v[c] || (exp_v[c] && o_data !== exp_d[c])) begin
                n_fail++;
                $display("FAIL stream[%0d]: got v=%b d=%h want v=%b d=%h", c, o_valid, o_data, exp_v[c], exp_d[c]);
            end
        end
    endtask

    task automatic test_fill_stall();
        logic [W-1:0] beats [3];
        logic [W-1:0] drain [3];
        beats = '{8'hA1, 8'hA2, 8'hA3};
        drain = '{8'hA2, 8'hA3, 8'hA4};
        for (int c = 0; c < 3; c++) begin
            drive(1'b1, beats[c], 1'b0);
            tick();
        end
        drive(1'b1, 8'hA4, 1'b0);
        n_cmp++;
        if (o_ready !== 1'b0 || o_valid !== 1'b1 || o_data !== 8'hA1) begin
            n_fail++; $display("FAIL fill_full: got rdy=%b v=%b d=%h want rdy=0 v=1 d=a1", o_ready, o_valid, o_data);
        end
        tick();
        n_cmp++;
        if (o_valid !== 1'b1 || o_data !== 8'hA1) begin
            n_fail++; $display("FAIL fill_hold: got v=%b d=%h want v=1 d=a1", o_valid, o_data);
        end
        drive(1'b1, 8'hA4, 1'b1);
        n_cmp++;
        if (o_ready !== 1'b1) begin
            n_fail++; $display("FAIL fill_release_ready: got %b want 1", o_ready);
        end
        tick();
        for (int c = 0; c < 3; c++) begin
            drive(1'b0, 8'h00, 1'b1);
            n_cmp++;
            if (o_valid !== 1'b1 || o_data !== drain[c]) begin
                n_fail++; $display("FAIL fill_drain[%0d]: got v=%b d=%h want v=1 d=%h", c, o_valid, o_data, drain[c]);
            end
            tick();
        end
        n_cmp++;
        if (o_valid !== 1'b0) begin
            n_fail++; $display("FAIL fill_empty: got v=%b want 0", o_valid);
        end
    endtask

    task automatic test_full_passthrough();
        drive(1'b1, 8'hB1, 1'b0); tick();
        drive(1'b1, 8'hB2, 1'b0); tick();
        drive(1'b1, 8'hB3, 1'b0); tick();
        drive(1'b1, 8'hB4, 1'b1);
        n_cmp++;
        if (o_ready !== 1'b1 || o_data !== 8'hB1) begin
            n_fail++; $display("FAIL pass_ready: got rdy=%b d=%h want rdy=1 d=b1", o_ready, o_data);
        end
        tick();
        drive(1'b1, 8'hB5, 1'b0);
        n_cmp++;
        if (o_valid !== 1'b1 || o_data !== 8'hB2 || o_ready !== 1'b0) begin
            n_fail++; $display("FAIL pass_still_full: got v=%b d=%h rdy=%b want v=1 d=b2 rdy=0", o_valid, o_data, o_ready);
        end
`ifdef ELASTIC_PIPE_COUNT_EN
        n_cmp++;
        if (o_count !== 2'd3) begin
            n_fail++; $display("FAIL pass_count: got %0d want 3", o_count);
        end
`endif
        drive(1'b0, 8'h00, 1'b1);
        tick(); tick();
        n_cmp++;
        if (o_valid !== 1'b1 || o_data !== 8'hB4) begin
            n_fail++; $display("FAIL pass_last: got v=%b d=%h want v=1 d=b4", o_valid, o_data);
        end
        tick();
    endtask

    task automatic test_flush();
        drive(1'b1, 8'hC1, 1'b1); tick();
        drive(1'b1, 8'hC2, 1'b1); tick();
        i_flush = 1'b1;
        drive(1'b1, 8'hC3, 1'b1);
        n_cmp++;
        if (o_ready !== 1'b0) begin
            n_fail++; $display("FAIL flush_ready: got %b want 0", o_ready);
        end
        tick();
        i_flush = 1'b0;
`ifdef ELASTIC_PIPE_COUNT_EN
        n_cmp++;
        if (o_count !== 2'd0) begin
            n_fail++; $display("FAIL flush_count: got %0d want 0", o_count);
        end
`endif
        drive(1'b0, 8'h00, 1'b1);
        for (int c = 0; c < 3; c++) begin
            n_cmp++;
            if (o_valid !== 1'b0) begin
                n_fail++; $display("FAIL flush_no_emit[%0d]: got v=%b want 0", c, o_valid);
            end
            tick();
        end
        drive(1'b1, 8'h5C, 1'b1); tick();
        drive(1'b0, 8'h00, 1'b1); tick(); tick();
        n_cmp++;
        if (o_valid !== 1'b1 || o_data !== 8'h5C) begin
            n_fail++; $display("FAIL flush_next_beat: got v=%b d=%h want v=1 d=5c", o_valid, o_data);
        end
        tick();
        n_cmp++;
        if (o_valid !== 1'b0) begin
            n_fail++; $display("FAIL flush_next_once: got v=%b want 0", o_valid);
        end
    endtask

    task automatic test_enable();
        drive(1'b1, 8'h77, 1'b1); tick();
        drive(1'b0, 8'h00, 1'b1); tick(); tick();
        i_enable = 1'b0;
        drive(1'b1, 8'h99, 1'b1);
        n_cmp++;
        if (o_ready !== 1'b0) begin
            n_fail++; $display("FAIL enable_ready: got %b want 0", o_ready);
        end
        for (int c = 0; c < 4; c++) begin
            tick();
            n_cmp++;
            if (o_valid !== 1'b1 || o_data !== 8'h77) begin
                n_fail++; $display("FAIL enable_hold[%0d]: got v=%b d=%h want v=1 d=77", c, o_valid, o_data);
            end
        end
        i_enable = 1'b1;
        drive(1'b0, 8'h00, 1'b1);
        tick();
        n_cmp++;
        if (o_valid !== 1'b0) begin
            n_fail++; $display("FAIL enable_once: got v=%b want 0", o_valid);
        end
        tick();
        n_cmp++;
        if (o_valid !== 1'b0) begin
            n_fail++; $display("FAIL enable_no_dup: got v=%b want 0", o_valid);
        end
    endtask

    task automatic test_reset_midstream();
        drive(1'b1, 8'hD1, 1'b0); tick();
        drive(1'b1, 8'hD2, 1'b0); tick();
        drive(1'b1, 8'hD3, 1'b0); tick();
        i_reset = 1'b1;
        drive(1'b1, 8'hD4, 1'b1);
        n_cmp++;
        if (o_ready !== 1'b0) begin
            n_fail++; $display("FAIL rstmid_ready: got %b want 0", o_ready);
        end
        tick();
        n_cmp++;
        if (o_valid !== 1'b0 || o_data !== RST_D) begin
            n_fail++; $display("FAIL rstmid_out: got v=%b d=%h want v=0 d=%h", o_valid, o_data, RST_D);
        end
        i_reset = 1'b0;
        drive(1'b0, 8'h00, 1'b1);
        n_cmp++;
        if (o_ready !== 1'b1) begin
            n_fail++; $display("FAIL rstmid_release_ready: got %b want 1", o_ready);
        end
        tick(); tick(); tick();
        n_cmp++;
        if (o_valid !== 1'b0) begin
            n_fail++; $display("FAIL rstmid_no_emit: got v=%b want 0", o_valid);
        end
    endtask

    initial begin
        #1;
        test_reset();
        test_stream();
        test_fill_stall();
        test_full_passthrough();
        test_flush();
        test_enable();
        test_reset_midstream();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
